// File: rtl/alu_serial_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: ALU control words,
// slice operation codes and FSM state codes.
package alu_serial_ctrl_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_serial_ctrl_alu_top.sv
// 1-bit ALU slice: optional operand inversion, AND/OR/full-add/less select.
// set exposes the raw sum bit so the MSB slice can drive set-less-than.
module alu_top
  import alu_serial_ctrl_pkg::*;
(
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout,
  output logic       set
);

  logic a, b, sum;

  assign a    = src1 ^ A_invert;
  assign b    = src2 ^ B_invert;
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
  assign set  = sum;

  always_comb begin
    result = 1'b0;
    case (operation)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial WIDTH-bit ALU sequencer driving one alu_top slice LSB first,
// with the carry rippled through a flop and the result assembled in a shift register.
//
// state   | meaning
// IDLE    | waiting for start_i, outputs hold last result
// RUN     | one operand bit per cycle through the slice, cnt_q = bit index
// DONE    | result/flags valid, done_o pulse
module alu_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);
  import alu_serial_ctrl_pkg::*;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_sh, b_sh, r_sh;
  logic [3:0]         ctrl_q;
  logic               carry_q;
  logic               slice_result, slice_cout, slice_set;
  logic               last_bit, ovf, slt_bit;
  logic [WIDTH-1:0]   r_next, res_final;

  alu_top u_slice (
    .src1      (a_sh[0]),
    .src2      (b_sh[0]),
    .less      (1'b0),
    .A_invert  (ctrl_q[3]),
    .B_invert  (ctrl_q[2]),
    .cin       (carry_q),
    .operation (ctrl_q[1:0]),
    .result    (slice_result),
    .cout      (slice_cout),
    .set       (slice_set)
  );

  assign last_bit  = (state_q == ST_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign r_next    = {slice_result, r_sh[WIDTH-1:1]};
  // On the last bit carry_q is the carry into the MSB, slice_cout the carry out of it.
  assign ovf       = carry_q ^ slice_cout;
  assign slt_bit   = slice_set ^ ovf;
  assign res_final = (ctrl_q[1:0] == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : r_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i)  state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      ctrl_q     <= '0;
      carry_q    <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        a_sh    <= src1_i;
        b_sh    <= src2_i;
        ctrl_q  <= ALU_ctrl_i;
        carry_q <= ALU_ctrl_i[2];
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        r_sh    <= r_next;
        carry_q <= slice_cout;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (last_bit) begin
        result_o   <= res_final;
        zero_o     <= (res_final == '0);
        cout_o     <= slice_cout;
        overflow_o <= (ctrl_q[1:0] == OP_ADD) ? ovf : 1'b0;
      end
    end
  end

  assign done_o = (state_q == ST_DONE);
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl: arithmetic/logic vectors,
// latency, ignored start, back-to-back throughput and mid-operation reset.
module tb_alu_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src1, src2;
  logic [3:0]  ctrl;
  logic [31:0] result;
  logic        zero, cout, overflow, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .src1_i     (src1),
    .src2_i     (src2),
    .ALU_ctrl_i (ctrl),
    .result_o   (result),
    .zero_o     (zero),
    .cout_o     (cout),
    .overflow_o (overflow),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents start in cycle 0 (at a negedge), scrambles inputs afterwards,
  // returns the cycle index at which done_o is seen.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    src1 = a; src2 = b; ctrl = c; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        ctrl  = 4'($urandom_range(0, 15));
      end
    end while (!done && lat < 100);
    if (lat >= 100) chk("done_timeout", 32'(lat), 32'd33);
  endtask

  int lat, dones, first_done, second_done;

  initial begin
    rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; ctrl = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {28'h0, zero, cout, overflow, done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    do_op(4'b0010, 32'd5, 32'd7, lat);
    chk("add_latency", 32'(lat), 32'd33);
    chk("add_result", result, 32'd12);
    chk("add_flags", {29'h0, zero, cout, overflow}, 32'b000);
    chk("add_busy_done", {30'h0, busy, done}, 32'b11);
    @(negedge clk);
    chk("done_one_cycle", {30'h0, busy, done}, 32'b00);
    chk("result_held", result, 32'd12);

    do_op(4'b0110, 32'd7, 32'd7, lat);
    chk("sub_eq_result", result, 32'h0);
    chk("sub_eq_flags", {29'h0, zero, cout, overflow}, 32'b110);

    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, lat);
    chk("add_ovf_result", result, 32'h8000_0000);
    chk("add_ovf_flags", {29'h0, zero, cout, overflow}, 32'b001);

    do_op(4'b0110, 32'h8000_0000, 32'h1, lat);
    chk("sub_ovf_result", result, 32'h7FFF_FFFF);
    chk("sub_ovf_flags", {29'h0, zero, cout, overflow}, 32'b011);

    do_op(4'b0111, 32'hFFFF_FFFD, 32'h2, lat);
    chk("slt_neg_result", result, 32'h1);
    chk("slt_neg_ovf", {31'h0, overflow}, 32'h0);

    do_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, lat);
    chk("slt_ovf_result", result, 32'h0);
    chk("slt_ovf_zero", {31'h0, zero}, 32'h1);

    do_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    chk("and_result", result, 32'hF000_F000);
    chk("and_ovf", {31'h0, overflow}, 32'h0);

    do_op(4'b1100, 32'h0, 32'h0, lat);
    chk("nor_result", result, 32'hFFFF_FFFF);
    chk("nor_flags", {29'h0, zero, cout, overflow}, 32'b010);

    // start pulsed mid-RUN must be ignored: exactly one done over 80 cycles
    @(negedge clk);
    src1 = 32'd20; src2 = 32'd22; ctrl = 4'b0010; start = 1'b1;
    dones = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (done) dones++;
    end
    chk("ignored_start_dones", 32'(dones), 32'd1);
    chk("ignored_start_result", result, 32'd42);

    // start held high: back-to-back ops every 34 cycles
    @(negedge clk);
    src1 = 32'd1; src2 = 32'd1; ctrl = 4'b0010; start = 1'b1;
    first_done = -1; second_done = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    start = 1'b0;
    chk("held_first_done", 32'(first_done), 32'd33);
    chk("held_period", 32'(second_done - first_done), 32'd34);
    chk("held_result", result, 32'd2);
    repeat (40) @(negedge clk);

    // reset at RUN cycle 10 aborts with cleared outputs and no done
    do_op(4'b1100, 32'h0, 32'h0, lat);
    @(negedge clk);
    src1 = 32'd9; src2 = 32'd9; ctrl = 4'b0010; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_done", {30'h0, busy, done}, 32'b00);
    chk("abort_result", result, 32'h0);
    chk("abort_flags", {29'h0, zero, cout, overflow}, 32'b000);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    do_op(4'b0010, 32'd100, 32'd23, lat);
    chk("post_abort_latency", 32'(lat), 32'd33);
    chk("post_abort_result", result, 32'd123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
